fp_multiplier_pipe: RTL

FP_MULTIPLIER_PIPE -- requirements
Module: fp_multiplier_pipe

---
 rtl/fp_multiplier_pipe.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/fp_multiplier_pipe.sv
// Three-stage pipelined IEEE-754-style multiplier: subnormals are read and flushed as zero, five rounding modes.
// Define FPMUL_STICKY_FLAGS_EN to add the sticky_flags/flag_clr accumulator.
module fp_multiplier_pipe #(
  parameter int EXP_WIDTH  = 8,
  parameter int MANT_WIDTH = 23
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [EXP_WIDTH+MANT_WIDTH:0] a,
  input  logic [EXP_WIDTH+MANT_WIDTH:0] b,
  input  logic [2:0]                    rnd_mode,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [EXP_WIDTH+MANT_WIDTH:0] product,
  output logic [3:0]                    exception_flags
`ifdef FPMUL_STICKY_FLAGS_EN
  ,
  output logic [3:0]                    sticky_flags,
  input  logic                          flag_clr
`endif
);

  localparam int W  = 1 + EXP_WIDTH + MANT_WIDTH;
  localparam int EW = EXP_WIDTH + 2;
  localparam int PW = 2 * MANT_WIDTH + 2;
  localparam logic [EW-1:0]        BIAS     = EW'((1 << (EXP_WIDTH - 1)) - 1);
  localparam logic [EXP_WIDTH-1:0] EXP_ONES = '1;
  localparam logic [EXP_WIDTH-1:0] EXP_MAX  = {{(EXP_WIDTH-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {K_NORM, K_ZERO, K_INF, K_NAN} kind_t;

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Operand capture register
  logic         r0_vld;
  logic [W-1:0] r0_a, r0_b;
  logic [2:0]   r0_mode;

  // S1: unpack / classify / exponent sum / mantissa product
  logic [EXP_WIDTH-1:0]  ea, eb;
  logic [MANT_WIDTH-1:0] ma, mb;
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [PW-1:0] sig_a, sig_b, prod_d;
  logic [EW-1:0] exp_sum_d;
  kind_t         kind_d;
  logic          inv_d;

  assign ea     = r0_a[W-2 -: EXP_WIDTH];
  assign eb     = r0_b[W-2 -: EXP_WIDTH];
  assign ma     = r0_a[MANT_WIDTH-1:0];
  assign mb     = r0_b[MANT_WIDTH-1:0];
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == EXP_ONES) && (ma == '0);
  assign b_inf  = (eb == EXP_ONES) && (mb == '0);
  assign a_nan  = (ea == EXP_ONES) && (ma != '0);
  assign b_nan  = (eb == EXP_ONES) && (mb != '0);

  assign sig_a     = {{(PW-MANT_WIDTH-1){1'b0}}, 1'b1, ma};
  assign sig_b     = {{(PW-MANT_WIDTH-1){1'b0}}, 1'b1, mb};
  assign prod_d    = sig_a * sig_b;
  assign exp_sum_d = {2'b00, ea} + {2'b00, eb} - BIAS;

  always_comb begin
    kind_d = K_NORM;
    inv_d  = 1'b0;
    if (a_nan || b_nan) begin
      kind_d = K_NAN;
      inv_d  = (a_nan && !ma[MANT_WIDTH-1]) || (b_nan && !mb[MANT_WIDTH-1]);
    end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
      kind_d = K_NAN;
      inv_d  = 1'b1;
    end else if (a_inf || b_inf) begin
      kind_d = K_INF;
    end else if (a_zero || b_zero) begin
      kind_d = K_ZERO;
    end
  end

  logic                  s1_vld, s1_sign, s1_inv;
  kind_t                 s1_kind;
  logic [EW-1:0]         s1_exp;
  logic [PW-1:0]         s1_prod;
  logic [2:0]            s1_mode;

  // S2: normalise the [1,4) significand product, then round
  logic [MANT_WIDTH-1:0] n_mant;
  logic                  n_g, n_s, inc;
  logic [EW-1:0]         n_exp, r_exp;
  logic [MANT_WIDTH:0]   rnd_sum;

  always_comb begin
    n_mant = s1_prod[PW-3 -: MANT_WIDTH];
    n_g    = s1_prod[MANT_WIDTH-1];
    n_s    = |s1_prod[MANT_WIDTH-2:0];
    n_exp  = s1_exp;
    if (s1_prod[PW-1]) begin
      n_mant = s1_prod[PW-2 -: MANT_WIDTH];
      n_g    = s1_prod[MANT_WIDTH];
      n_s    = |s1_prod[MANT_WIDTH-1:0];
      n_exp  = s1_exp + EW'(1);
    end
    case (s1_mode)
      3'b001:  inc = 1'b0;
      3'b010:  inc = s1_sign && (n_g || n_s);
      3'b011:  inc = !s1_sign && (n_g || n_s);
      3'b100:  inc = n_g;
      default: inc = n_g && (n_s || n_mant[0]);
    endcase
  end

  // A carry out of the mantissa leaves it all zeros; only the exponent moves
  assign rnd_sum = {1'b0, n_mant} + {{MANT_WIDTH{1'b0}}, inc};
  assign r_exp   = n_exp + {{(EW-1){1'b0}}, rnd_sum[MANT_WIDTH]};

  logic                  s2_vld, s2_sign, s2_inv, s2_inexact;
  kind_t                 s2_kind;
  logic [EW-1:0]         s2_exp;
  logic [MANT_WIDTH-1:0] s2_mant;
  logic [2:0]            s2_mode;

  // S3: range check, special-value pack, flags
  logic         ovf, unf, use_max;
  logic [W-1:0] p_d;
  logic [3:0]   f_d;

  assign ovf = !s2_exp[EW-1] && (s2_exp >= {2'b00, EXP_ONES});
  assign unf = s2_exp[EW-1] || (s2_exp == '0);

  always_comb begin
    p_d = '0;
    f_d = '0;
    case (s2_mode)
      3'b001:  use_max = 1'b1;
      3'b010:  use_max = !s2_sign;
      3'b011:  use_max = s2_sign;
      default: use_max = 1'b0;
    endcase
    case (s2_kind)
      K_NAN: begin
        p_d = {1'b0, EXP_ONES, 1'b1, {(MANT_WIDTH-1){1'b0}}};
        f_d = {s2_inv, 3'b000};
      end
      K_INF:  p_d = {s2_sign, EXP_ONES, {MANT_WIDTH{1'b0}}};
      K_ZERO: p_d = {s2_sign, {(W-1){1'b0}}};
      default: begin
        if (ovf) begin
          f_d = 4'b0101;
          p_d = use_max ? {s2_sign, EXP_MAX, {MANT_WIDTH{1'b1}}}
                        : {s2_sign, EXP_ONES, {MANT_WIDTH{1'b0}}};
        end else if (unf) begin
          f_d = 4'b0011;
          p_d = {s2_sign, {(W-1){1'b0}}};
        end else begin
          f_d = {3'b000, s2_inexact};
          p_d = {s2_sign, s2_exp[EXP_WIDTH-1:0], s2_mant};
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r0_vld  <= 1'b0;  r0_a <= '0;  r0_b <= '0;  r0_mode <= '0;
      s1_vld  <= 1'b0;  s1_sign <= 1'b0;  s1_inv <= 1'b0;  s1_kind <= K_NORM;
      s1_exp  <= '0;    s1_prod <= '0;    s1_mode <= '0;
      s2_vld  <= 1'b0;  s2_sign <= 1'b0;  s2_inv <= 1'b0;  s2_inexact <= 1'b0;
      s2_kind <= K_NORM; s2_exp <= '0;    s2_mant <= '0;   s2_mode <= '0;
      out_valid       <= 1'b0;
      product         <= '0;
      exception_flags <= '0;
    end else if (advance) begin
      r0_vld     <= in_valid;
      r0_a       <= a;
      r0_b       <= b;
      r0_mode    <= rnd_mode;
      s1_vld     <= r0_vld;
      s1_sign    <= r0_a[W-1] ^ r0_b[W-1];
      s1_inv     <= inv_d;
      s1_kind    <= kind_d;
      s1_exp     <= exp_sum_d;
      s1_prod    <= prod_d;
      s1_mode    <= r0_mode;
      s2_vld     <= s1_vld;
      s2_sign    <= s1_sign;
      s2_inv     <= s1_inv;
      s2_inexact <= n_g || n_s;
      s2_kind    <= s1_kind;
      s2_exp     <= r_exp;
      s2_mant    <= rnd_sum[MANT_WIDTH-1:0];
      s2_mode    <= s1_mode;
      out_valid  <= s2_vld;
      if (s2_vld) begin
        product         <= p_d;
        exception_flags <= f_d;
      end
    end
  end

`ifdef FPMUL_STICKY_FLAGS_EN
  // A clear coinciding with a handshake keeps only that beat's flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      sticky_flags <= '0;
    else if (out_valid && out_ready)
      sticky_flags <= flag_clr ? exception_flags : (sticky_flags | exception_flags);
    else if (flag_clr)
      sticky_flags <= '0;
  end
`endif

endmodule
